alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests from two independent clients (e.g. the two cores' execute stages, or execute plus a multicycle helper). It grants one request at a time under round-robin priority and drives the captured opcode and operands into the ALU for one cycle. It then registers the ALU's result and flags and holds them until the owning client acknowledges. It sits between the clients and the single `alu` instance and owns the ALU's input ports.

---
 rtl/alu_arbiter_if.sv | 54 +++++
 rtl/alu_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: client request/response and ALU-side bundle for alu_arbiter.
// The arbiter connects through the slave modport; the environment (clients
// plus the shared ALU) connects through the master modport.
interface alu_arbiter_if #(
    parameter int WORD_W = 32
) ();
    // client 0
    logic              req0_valid;
    logic              req0_ready;
    logic [3:0]        req0_op;
    logic [WORD_W-1:0] req0_a;
    logic [WORD_W-1:0] req0_b;
    logic              rsp0_valid;
    logic              rsp0_ack;
    // client 1
    logic              req1_valid;
    logic              req1_ready;
    logic [3:0]        req1_op;
    logic [WORD_W-1:0] req1_a;
    logic [WORD_W-1:0] req1_b;
    logic              rsp1_valid;
    logic              rsp1_ack;
    // shared response data
    logic [WORD_W-1:0] rsp_result;
    logic              rsp_negative;
    logic              rsp_zero;
    logic              rsp_overflow;
    // ALU side
    logic [3:0]        alu_op;
    logic [WORD_W-1:0] alu_port_a;
    logic [WORD_W-1:0] alu_port_b;
    logic [WORD_W-1:0] alu_result;
    logic              alu_negative;
    logic              alu_zero;
    logic              alu_overflow;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ack,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ack,
        output req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        output rsp_result, rsp_negative, rsp_zero, rsp_overflow,
        output alu_op, alu_port_a, alu_port_b,
        input  alu_result, alu_negative, alu_zero, alu_overflow
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ack,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ack,
        input  req0_ready, rsp0_valid, req1_ready, rsp1_valid,
        input  rsp_result, rsp_negative, rsp_zero, rsp_overflow,
        input  alu_op, alu_port_a, alu_port_b,
        output alu_result, alu_negative, alu_zero, alu_overflow
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client arbiter/sequencer in front of the shared ALU.
// IDLE grants one request (round-robin on ties), EXEC drives the captured
// operation into the combinational ALU for one cycle, RESP holds the
// registered result/flags until the owning client acknowledges.
// Optional build macro: ALU_ARB_FIXED_PRI_EN -- client 0 always wins ties
// (last_grant is still tracked but no longer steers arbitration).
module alu_arbiter #(
    parameter int WORD_W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic              last_grant_r;
    logic              owner_r;
    logic              grant0_s;
    logic              grant1_s;
    logic              accept0_s;
    logic              accept1_s;
    logic              accept_s;
    logic              owner_ack_s;
    logic [3:0]        alu_op_r;
    logic [WORD_W-1:0] alu_a_r;
    logic [WORD_W-1:0] alu_b_r;
    logic [WORD_W-1:0] rsp_result_r;
    logic              rsp_negative_r;
    logic              rsp_zero_r;
    logic              rsp_overflow_r;
    logic              rsp0_valid_r;
    logic              rsp1_valid_r;

    // Index of the client that wins when both request at once.
    function automatic logic tie_winner(input logic last_grant);
`ifdef ALU_ARB_FIXED_PRI_EN
        tie_winner = 1'b0 & last_grant;
`else
        tie_winner = ~last_grant;
`endif
    endfunction

    // Grant decode: only in IDLE, one client at most.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (state_r == ST_IDLE) begin
            case ({bus.req1_valid, bus.req0_valid})
                2'b01: grant0_s = 1'b1;
                2'b10: grant1_s = 1'b1;
                2'b11: begin
                    if (tie_winner(last_grant_r)) begin
                        grant1_s = 1'b1;
                    end else begin
                        grant0_s = 1'b1;
                    end
                end
                default: begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
            endcase
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept0_s   = bus.req0_valid & grant0_s;
    assign accept1_s   = bus.req1_valid & grant1_s;
    assign accept_s    = accept0_s | accept1_s;
    // Only the owner's acknowledge counts; the other client's is ignored.
    assign owner_ack_s = owner_r ? bus.rsp1_ack : bus.rsp0_ack;

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_RESP;
            ST_RESP: begin
                if (owner_ack_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; reset discards any in-flight operation.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Owner and round-robin history, updated on every acceptance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            owner_r      <= accept1_s;
            last_grant_r <= accept1_s;
        end else begin
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end
    end

    // ALU input registers: loaded on acceptance, otherwise hold the last op.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            alu_op_r <= 4'd0;
            alu_a_r  <= '0;
            alu_b_r  <= '0;
        end else if (accept1_s) begin
            alu_op_r <= bus.req1_op;
            alu_a_r  <= bus.req1_a;
            alu_b_r  <= bus.req1_b;
        end else if (accept0_s) begin
            alu_op_r <= bus.req0_op;
            alu_a_r  <= bus.req0_a;
            alu_b_r  <= bus.req0_b;
        end else begin
            alu_op_r <= alu_op_r;
            alu_a_r  <= alu_a_r;
            alu_b_r  <= alu_b_r;
        end
    end

    // Response data: captured from the ALU at the end of EXEC, then frozen.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_result_r   <= '0;
            rsp_negative_r <= 1'b0;
            rsp_zero_r     <= 1'b0;
            rsp_overflow_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp_result_r   <= bus.alu_result;
            rsp_negative_r <= bus.alu_negative;
            rsp_zero_r     <= bus.alu_zero;
            rsp_overflow_r <= bus.alu_overflow;
        end else begin
            rsp_result_r   <= rsp_result_r;
            rsp_negative_r <= rsp_negative_r;
            rsp_zero_r     <= rsp_zero_r;
            rsp_overflow_r <= rsp_overflow_r;
        end
    end

    // Per-client response valid: set for the owner leaving EXEC, cleared on its ack.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            rsp0_valid_r <= ~owner_r;
            rsp1_valid_r <= owner_r;
        end else if ((state_r == ST_RESP) && owner_ack_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            rsp0_valid_r <= rsp0_valid_r;
            rsp1_valid_r <= rsp1_valid_r;
        end
    end

    assign bus.req0_ready   = grant0_s;
    assign bus.req1_ready   = grant1_s;
    assign bus.rsp0_valid   = rsp0_valid_r;
    assign bus.rsp1_valid   = rsp1_valid_r;
    assign bus.rsp_result   = rsp_result_r;
    assign bus.rsp_negative = rsp_negative_r;
    assign bus.rsp_zero     = rsp_zero_r;
    assign bus.rsp_overflow = rsp_overflow_r;
    assign bus.alu_op       = alu_op_r;
    assign bus.alu_port_a   = alu_a_r;
    assign bus.alu_port_b   = alu_b_r;

endmodule
